// File: rtl/alu_serial_front_end_if.sv
// Host-side pin bundle of the ALU serial front end: enable, data bus,
// strobe/ack inputs, result bus and flag/status outputs.
interface alu_serial_front_end_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/alu_serial_front_end.sv
// Host front end for the 8-bit ALU tile: collects A, B and opcode over one
// strobed byte bus, executes, and holds result + flags until acknowledged.
module alu_serial_front_end #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                   clk,
    input logic                   rst_n,
    alu_serial_front_end_if.slave bus
);

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_OP,
        S_EXEC,
        S_RESULT
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [7:0]             a_q, a_d;
    logic [7:0]             b_q, b_d;
    logic [1:0]             op_q, op_d;
    logic [7:0]             result_q, result_d;
    logic                   carry_q, carry_d;
    logic                   zero_q, zero_d;
    logic                   err_q, err_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] stb_sync_q, ack_sync_q;
    logic                   stb_prev_q, ack_prev_q;
    logic                   stb_edge, ack_edge;
    logic [8:0]             alu_out;
    logic                   valid;
    logic [1:0]             phase;
    logic                   unused_uio;

    assign unused_uio = ^bus.uio_in[7:2];

    // Synchronizers and edge detectors run regardless of ena, so edges seen
    // while the tile is disabled are consumed and lost.
    // NOTE: every clocked process uses non-blocking assignments so all flops
    // update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_sync_q <= '0;
            ack_sync_q <= '0;
            stb_prev_q <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], bus.uio_in[0]};
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.uio_in[1]};
            stb_prev_q <= stb_sync_q[SYNC_STAGES-1];
            ack_prev_q <= ack_sync_q[SYNC_STAGES-1];
        end
    end

    assign stb_edge = stb_sync_q[SYNC_STAGES-1] & ~stb_prev_q;
    assign ack_edge = ack_sync_q[SYNC_STAGES-1] & ~ack_prev_q;

    // Bit 8 is carry for ADD and borrow for SUB (9-bit wrap when A < B).
    always_comb begin
        unique case (op_q)
            2'b00:   alu_out = {1'b0, a_q} + {1'b0, b_q};
            2'b01:   alu_out = {1'b0, a_q} - {1'b0, b_q};
            2'b10:   alu_out = {1'b0, a_q & b_q};
            default: alu_out = {1'b0, a_q | b_q};
        endcase
    end

    // NOTE: every next-state signal is defaulted to its current value before
    // the case so no path through this block can infer a latch.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        if (bus.ena) begin
            unique case (state_q)
                S_LOAD_A: begin
                    cnt_d = '0;
                    if (stb_edge) begin
                        a_d     = bus.ui_in;
                        err_d   = 1'b0;
                        state_d = S_LOAD_B;
                    end
                end
                S_LOAD_B, S_LOAD_OP: begin
                    // An accepted byte takes priority over a coincident expiry.
                    if (stb_edge) begin
                        cnt_d = '0;
                        if (state_q == S_LOAD_B) begin
                            b_d     = bus.ui_in;
                            state_d = S_LOAD_OP;
                        end else begin
                            op_d    = bus.ui_in[1:0];
                            state_d = S_EXEC;
                        end
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_LOAD_A;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_EXEC: begin
                    cnt_d    = '0;
                    result_d = alu_out[7:0];
                    carry_d  = alu_out[8];
                    zero_d   = (alu_out[7:0] == 8'h00);
                    state_d  = S_RESULT;
                end
                S_RESULT: begin
                    cnt_d = '0;
                    if (ack_edge) state_d = S_LOAD_A;
                end
                default: state_d = S_LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        unique case (state_q)
            S_LOAD_A:  phase = 2'b00;
            S_LOAD_B:  phase = 2'b01;
            S_LOAD_OP: phase = 2'b10;
            default:   phase = 2'b11;
        endcase
    end

    assign valid       = (state_q == S_RESULT);
    assign bus.uo_out  = result_q;
    assign bus.uio_out = {err_q, zero_q, carry_q, valid, phase, 2'b00};
    assign bus.uio_oe  = 8'hFC;

endmodule

// File: tb/tb_alu_serial_front_end.sv
// Directed bench for alu_serial_front_end: a vector table of ALU operations
// plus hand-written sequences for timeout, held strobes, ena and async reset.
module tb_alu_serial_front_end;

    localparam int TB_TIMEOUT = 40;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] res;
        logic       carry;
        logic       zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_serial_front_end_if bus ();

    alu_serial_front_end #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // Raise strobe and/or ack at a falling edge; the DUT acts on the third
    // rising edge after that. Returns at the falling edge right after the
    // acting edge, with both pins dropped again.
    task automatic pulse(input logic stb, input logic ack, input logic [7:0] d);
        @(negedge clk);
        bus.ui_in     = d;
        bus.uio_in[0] = stb;
        bus.uio_in[1] = ack;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.uio_in[1:0] = 2'b00;
    endtask

    task automatic strobe(input logic [7:0] d);
        pulse(1'b1, 1'b0, d);
    endtask

    task automatic ack();
        pulse(1'b0, 1'b1, bus.ui_in);
    endtask

    function automatic logic [1:0] phase();
        return bus.uio_out[3:2];
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        strobe(v.a);
        check({tag, " phase after A"}, phase(), 2'b01);
        check({tag, " err after A"}, bus.uio_out[7], 1'b0);
        strobe(v.b);
        check({tag, " phase after B"}, phase(), 2'b10);
        strobe({6'b101101, v.op});
        check({tag, " exec phase"}, phase(), 2'b11);
        check({tag, " exec valid"}, bus.uio_out[4], 1'b0);
        @(negedge clk);
        check({tag, " valid"}, bus.uio_out[4], 1'b1);
        check({tag, " result"}, bus.uo_out, v.res);
        check({tag, " carry"}, bus.uio_out[5], v.carry);
        check({tag, " zero"}, bus.uio_out[6], v.zero);
        check({tag, " low bits"}, bus.uio_out[1:0], 2'b00);
        ack();
        check({tag, " valid after ack"}, bus.uio_out[4], 1'b0);
        check({tag, " phase after ack"}, phase(), 2'b00);
        check({tag, " result held"}, bus.uo_out, v.res);
    endtask

    vec_t vecs[8];
    vec_t v;

    initial begin
        vecs[0] = '{a: 8'h3C, b: 8'h14, op: 2'b00, res: 8'h50, carry: 1'b0, zero: 1'b0};
        vecs[1] = '{a: 8'hF0, b: 8'h20, op: 2'b00, res: 8'h10, carry: 1'b1, zero: 1'b0};
        vecs[2] = '{a: 8'h05, b: 8'h05, op: 2'b01, res: 8'h00, carry: 1'b0, zero: 1'b1};
        vecs[3] = '{a: 8'h03, b: 8'h04, op: 2'b01, res: 8'hFF, carry: 1'b1, zero: 1'b0};
        vecs[4] = '{a: 8'hCA, b: 8'h0F, op: 2'b10, res: 8'h0A, carry: 1'b0, zero: 1'b0};
        vecs[5] = '{a: 8'hCA, b: 8'h0F, op: 2'b11, res: 8'hCF, carry: 1'b0, zero: 1'b0};
        vecs[6] = '{a: 8'hFF, b: 8'h01, op: 2'b00, res: 8'h00, carry: 1'b1, zero: 1'b1};
        vecs[7] = '{a: 8'h50, b: 8'h0A, op: 2'b01, res: 8'h46, carry: 1'b0, zero: 1'b0};

        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset uo_out", bus.uo_out, 8'h00);
        check("reset uio_out", bus.uio_out, 8'h00);
        check("uio_oe", bus.uio_oe, 8'hFC);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Timeout: after A, TB_TIMEOUT idle cycles abort back to LOAD_A.
        strobe(8'h77);
        repeat (TB_TIMEOUT - 1) @(negedge clk);
        check("timeout not yet phase", phase(), 2'b01);
        check("timeout not yet err", bus.uio_out[7], 1'b0);
        @(negedge clk);
        check("timeout phase", phase(), 2'b00);
        check("timeout err", bus.uio_out[7], 1'b1);
        repeat (5) @(negedge clk);
        check("err sticky", bus.uio_out[7], 1'b1);
        strobe(8'h40);
        check("err cleared by A", bus.uio_out[7], 1'b0);
        // B strobe lands exactly on the expiry cycle and must win.
        repeat (TB_TIMEOUT - 4) @(negedge clk);
        strobe(8'h02);
        check("expiry strobe phase", phase(), 2'b10);
        check("expiry strobe err", bus.uio_out[7], 1'b0);
        strobe(8'h00);
        @(negedge clk);
        check("expiry add result", bus.uo_out, 8'h42);
        check("expiry add valid", bus.uio_out[4], 1'b1);
        ack();

        // Held strobe counts once.
        @(negedge clk);
        bus.ui_in     = 8'h11;
        bus.uio_in[0] = 1'b1;
        repeat (20) @(negedge clk);
        check("held strobe phase", phase(), 2'b01);
        bus.uio_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        strobe(8'h22);
        strobe(8'h00);
        @(negedge clk);
        check("held strobe result", bus.uo_out, 8'h33);

        // Strobes during RESULT are ignored; strobe+ack together takes the ack.
        strobe(8'h99);
        strobe(8'h98);
        check("result strobe phase", phase(), 2'b11);
        check("result strobe valid", bus.uio_out[4], 1'b1);
        check("result strobe uo_out", bus.uo_out, 8'h33);
        pulse(1'b1, 1'b1, 8'h55);
        check("stb+ack phase", phase(), 2'b00);
        check("stb+ack valid", bus.uio_out[4], 1'b0);

        // ena=0 in LOAD_B freezes state and timeout; ack outside RESULT ignored.
        strobe(8'h01);
        ack();
        check("ack in LOAD_B", phase(), 2'b01);
        bus.ena = 1'b0;
        strobe(8'hEE);
        repeat (TB_TIMEOUT + 20) @(negedge clk);
        check("ena0 phase", phase(), 2'b01);
        check("ena0 err", bus.uio_out[7], 1'b0);
        bus.ena = 1'b1;
        repeat (2) @(negedge clk);
        check("ena1 no replay", phase(), 2'b01);
        strobe(8'h02);
        strobe(8'h00);
        @(negedge clk);
        check("ena result", bus.uo_out, 8'h03);
        ack();

        // Async reset in LOAD_OP clears everything without a clock edge.
        strobe(8'h12);
        strobe(8'h34);
        check("pre-reset phase", phase(), 2'b10);
        rst_n = 1'b0;
        #1;
        check("async reset uo_out", bus.uo_out, 8'h00);
        check("async reset uio_out", bus.uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{a: 8'h81, b: 8'h7F, op: 2'b00, res: 8'h00, carry: 1'b1, zero: 1'b1};
        run_vec(v, "post-reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
